// File: rtl/bp_decode_scheduler.sv
// -----------------------------------------------------------------------------
// bp_decode_scheduler
//
// Sequences a belief-propagation decoder datapath through alternating row
// (check-node) and column (variable-node) phases. Each decode runs:
//   INIT -> { ROW_GO -> ROW_WAIT -> ROW_WB -> COL_GO -> COL_WAIT -> COL_WB
//             -> CHECK } x N -> DONE
// It stops early on a zero syndrome, caps the number of iterations and raises
// timeout_err if any wait state exceeds TIMEOUT cycles.
//
// Ports
//   clk, reset                           clock, asynchronous active-high reset
//   start                                begin a decode (sampled only when idle)
//   max_iterations                       iteration cap, latched at start (0 -> 1)
//   done_row_processing                  per row-unit completion flags
//   done_column_processing               per column-unit completion flags
//   syndrome_valid, syndrome_zero        syndrome result from the datapath
//   start_row_processing                 1-cycle launch of the row phase
//   start_column_processing              1-cycle launch of the column phase
//   initialize_parity_check_matrix       load received LLRs (INIT only)
//   load_parity_check_matrix             matrix register write enable
//   select_input_to_parity_check_matrix  0 = received vector, 1 = messages
//   load_sum_vector                      capture posterior sums
//   busy                                 decode in progress
//   done                                 1-cycle end-of-decode pulse
//   converged, timeout_err               decode outcome, valid with done
//   iterations_used                      completed iterations, held until start
// -----------------------------------------------------------------------------
module bp_decode_scheduler #(
    parameter int ROWS    = 3,
    parameter int COLS    = 6,
    parameter int ITER_W  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ITER_W-1:0] max_iterations,
    input  logic [ROWS-1:0]   done_row_processing,
    input  logic [COLS-1:0]   done_column_processing,
    input  logic              syndrome_valid,
    input  logic              syndrome_zero,
    output logic              start_row_processing,
    output logic              start_column_processing,
    output logic              initialize_parity_check_matrix,
    output logic              load_parity_check_matrix,
    output logic              select_input_to_parity_check_matrix,
    output logic              load_sum_vector,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic              timeout_err,
    output logic [ITER_W-1:0] iterations_used
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Last permitted wait cycle index; reaching it without completion is a hang.
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_ROW_GO,
        S_ROW_WAIT,
        S_ROW_WB,
        S_COL_GO,
        S_COL_WAIT,
        S_COL_WB,
        S_CHECK,
        S_ERR,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ITER_W-1:0] cap_q, cap_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [ROWS-1:0]   row_mask_q, row_mask_d;
    logic [COLS-1:0]   col_mask_q, col_mask_d;
    logic              conv_q, conv_d;
    logic              terr_q, terr_d;

    logic start_row_q, start_col_q, init_q, load_pcm_q, select_q, load_sum_q;
    logic busy_q, done_q;

    // Same-cycle completion counts: a unit finishing in the cycle the mask
    // would otherwise become complete must not cost an extra cycle.
    logic [ROWS-1:0] row_seen;
    logic [COLS-1:0] col_seen;
    assign row_seen = row_mask_q | done_row_processing;
    assign col_seen = col_mask_q | done_column_processing;

    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        iter_d     = iter_q;
        tcnt_d     = tcnt_q;
        row_mask_d = row_mask_q;
        col_mask_d = col_mask_q;
        conv_d     = conv_q;
        terr_d     = terr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    cap_d   = (max_iterations == '0) ? ITER_W'(1) : max_iterations;
                    iter_d  = '0;
                    conv_d  = 1'b0;
                    terr_d  = 1'b0;
                end
            end
            S_INIT: state_d = S_ROW_GO;
            S_ROW_GO: begin
                row_mask_d = '0;
                tcnt_d     = '0;
                state_d    = S_ROW_WAIT;
            end
            S_ROW_WAIT: begin
                row_mask_d = row_seen;
                if (&row_seen) begin
                    state_d = S_ROW_WB;
                end else if (tcnt_q == TLAST) begin
                    state_d = S_ERR;
                    terr_d  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_ROW_WB: state_d = S_COL_GO;
            S_COL_GO: begin
                col_mask_d = '0;
                tcnt_d     = '0;
                state_d    = S_COL_WAIT;
            end
            S_COL_WAIT: begin
                col_mask_d = col_seen;
                if (&col_seen) begin
                    state_d = S_COL_WB;
                end else if (tcnt_q == TLAST) begin
                    state_d = S_ERR;
                    terr_d  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_COL_WB: begin
                if (iter_q != {ITER_W{1'b1}}) begin
                    iter_d = iter_q + 1'b1;
                end
                tcnt_d  = '0;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (syndrome_valid) begin
                    if (syndrome_zero) begin
                        state_d = S_DONE;
                        conv_d  = 1'b1;
                    end else if (iter_q >= cap_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ROW_GO;
                    end
                end else if (tcnt_q == TLAST) begin
                    state_d = S_ERR;
                    terr_d  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_ERR:   state_d = S_IDLE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and outputs share one register stage; strobes are decoded from the
    // next state so they are high exactly while the FSM sits in that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cap_q       <= '0;
            iter_q      <= '0;
            tcnt_q      <= '0;
            row_mask_q  <= '0;
            col_mask_q  <= '0;
            conv_q      <= 1'b0;
            terr_q      <= 1'b0;
            start_row_q <= 1'b0;
            start_col_q <= 1'b0;
            init_q      <= 1'b0;
            load_pcm_q  <= 1'b0;
            select_q    <= 1'b0;
            load_sum_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            iter_q      <= iter_d;
            tcnt_q      <= tcnt_d;
            row_mask_q  <= row_mask_d;
            col_mask_q  <= col_mask_d;
            conv_q      <= conv_d;
            terr_q      <= terr_d;
            start_row_q <= (state_d == S_ROW_GO);
            start_col_q <= (state_d == S_COL_GO);
            init_q      <= (state_d == S_INIT);
            load_pcm_q  <= (state_d == S_INIT) || (state_d == S_ROW_WB) || (state_d == S_COL_WB);
            select_q    <= (state_d == S_ROW_WB) || (state_d == S_COL_WB);
            load_sum_q  <= (state_d == S_COL_WB);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE) || (state_d == S_ERR);
        end
    end

    assign start_row_processing                = start_row_q;
    assign start_column_processing             = start_col_q;
    assign initialize_parity_check_matrix      = init_q;
    assign load_parity_check_matrix            = load_pcm_q;
    assign select_input_to_parity_check_matrix = select_q;
    assign load_sum_vector                     = load_sum_q;
    assign busy                                = busy_q;
    assign done                                = done_q;
    assign converged                           = conv_q;
    assign timeout_err                         = terr_q;
    assign iterations_used                     = iter_q;

endmodule

// File: tb/tb_bp_decode_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bp_decode_scheduler
//
// Directed bench. For each decode an event-schedule model computes, from the
// phase timing rules, which strobes must be high on every cycle and what the
// held outcome outputs must read; one compare step checks the DUT against it
// every cycle. A responder plays the row/column units and syndrome checker.
// -----------------------------------------------------------------------------
module tb_bp_decode_scheduler;

    localparam int ROWS   = 3;
    localparam int COLS   = 6;
    localparam int ITER_W = 4;
    localparam int TO     = 16;
    localparam int MAXC   = 256;

    // Output-vector bit positions: {busy,init,lpcm,sel,lsum,srow,scol,done}
    localparam logic [7:0] V_DONE = 8'h01;
    localparam logic [7:0] V_SCOL = 8'h02;
    localparam logic [7:0] V_SROW = 8'h04;
    localparam logic [7:0] V_LSUM = 8'h08;
    localparam logic [7:0] V_SEL  = 8'h10;
    localparam logic [7:0] V_LPCM = 8'h20;
    localparam logic [7:0] V_INIT = 8'h40;
    localparam logic [7:0] V_BUSY = 8'h80;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ITER_W-1:0] max_iterations;
    logic [ROWS-1:0]   done_row;
    logic [COLS-1:0]   done_col;
    logic              syndrome_valid;
    logic              syndrome_zero;
    logic              srow, scol, init_o, lpcm, sel, lsum, busy, done, conv, terr;
    logic [ITER_W-1:0] iters;

    bp_decode_scheduler #(
        .ROWS(ROWS), .COLS(COLS), .ITER_W(ITER_W), .TIMEOUT(TO)
    ) dut (
        .clk                                (clk),
        .reset                              (reset),
        .start                              (start),
        .max_iterations                     (max_iterations),
        .done_row_processing                (done_row),
        .done_column_processing             (done_col),
        .syndrome_valid                     (syndrome_valid),
        .syndrome_zero                      (syndrome_zero),
        .start_row_processing               (srow),
        .start_column_processing            (scol),
        .initialize_parity_check_matrix     (init_o),
        .load_parity_check_matrix           (lpcm),
        .select_input_to_parity_check_matrix(sel),
        .load_sum_vector                    (lsum),
        .busy                               (busy),
        .done                               (done),
        .converged                          (conv),
        .timeout_err                        (terr),
        .iterations_used                    (iters)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-unit response delay in cycles after the launch strobe; 0 = never.
    int row_dl[ROWS];
    int col_dl[COLS];
    bit noise;

    logic [7:0] exp_vec[MAXC];
    int         exp_iter[MAXC];
    int         exp_conv[MAXC];
    int         exp_to[MAXC];

    int obs_done, obs_rowwb, obs_nrow;

    function automatic logic [7:0] obs_vec();
        return {busy, init_o, lpcm, sel, lsum, srow, scol, done};
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Builds the expected per-cycle schedule; cycle 0 is the cycle start is
    // presented while idle.
    task automatic build_model(input int cap_in, input int zero_it, input int s,
                               output int done_c);
        int dr, dc, cap, pos, wb, nxt, cnt;
        bit hang, cv, to;
        dr = 0; dc = 0; hang = 0; cv = 0; to = 0; done_c = 0;
        foreach (row_dl[i]) if (row_dl[i] > dr) dr = row_dl[i];
        foreach (col_dl[i]) begin
            if (col_dl[i] == 0) hang = 1;
            if (col_dl[i] > dc) dc = col_dl[i];
        end
        for (int c = 0; c < MAXC; c++) begin
            exp_vec[c] = '0; exp_iter[c] = 0; exp_conv[c] = 0; exp_to[c] = 0;
        end
        cap = (cap_in == 0) ? 1 : cap_in;
        exp_vec[1] |= V_INIT | V_LPCM;
        pos = 2;
        for (int it = 1; it <= 15; it++) begin
            exp_vec[pos]        |= V_SROW;
            exp_vec[pos+dr+1]   |= V_LPCM | V_SEL;
            exp_vec[pos+dr+2]   |= V_SCOL;
            if (hang) begin
                done_c = pos + dr + 3 + TO;
                to = 1;
                break;
            end
            wb = pos + dr + dc + 3;
            exp_vec[wb] |= V_LPCM | V_SEL | V_LSUM;
            nxt = wb + 1 + s + 1;
            if (it == zero_it) begin done_c = nxt; cv = 1; break; end
            if (it == cap)     begin done_c = nxt; break; end
            pos = nxt;
        end
        exp_vec[done_c] |= V_DONE;
        cnt = 0;
        for (int c = 1; c < MAXC; c++) begin
            if (c <= done_c) exp_vec[c] |= V_BUSY;
            exp_iter[c] = cnt;
            if ((exp_vec[c] & V_LSUM) != 0) cnt++;
            exp_conv[c] = (c >= done_c) ? int'(cv) : 0;
            exp_to[c]   = (c >= done_c) ? int'(to) : 0;
        end
    endtask

    task automatic clear_inputs();
        start = 1'b0; done_row = '0; done_col = '0;
        syndrome_valid = 1'b0; syndrome_zero = 1'b0;
    endtask

    task automatic run_decode(input string tag, input int cap, input int zero_it,
                              input int s, input int extra_start, input int abort_at);
        int done_c, rgo, cgo, lsc, nsum, last;
        build_model(cap, zero_it, s, done_c);
        last = done_c + 2;
        rgo = -1; cgo = -1; lsc = -1; nsum = 0;
        obs_done = -1; obs_rowwb = -1; obs_nrow = 0;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() != exp_vec[c]) begin
                errors++;
                $display("FAIL %s_strobes c=%0d: got %02h expected %02h", tag, c, obs_vec(), exp_vec[c]);
            end
            if (c >= 1) begin
                check_int($sformatf("%s_iters c=%0d", tag, c), int'(iters), exp_iter[c]);
                check_int($sformatf("%s_conv c=%0d", tag, c), int'(conv), exp_conv[c]);
                check_int($sformatf("%s_tout c=%0d", tag, c), int'(terr), exp_to[c]);
            end
            if (srow) begin rgo = c; obs_nrow++; end
            if (scol) cgo = c;
            if (lpcm && sel && !lsum && obs_rowwb < 0) obs_rowwb = c;
            if (done && obs_done < 0) obs_done = c;
            if (lsum) begin lsc = c; nsum++; end
            if (c == abort_at) begin
                #1 reset = 1'b1;
                #1;
                check_int({tag, "_rst_strobes"}, int'(obs_vec()), 0);
                check_int({tag, "_rst_iters"}, int'(iters), 0);
                check_int({tag, "_rst_flags"}, int'({conv, terr}), 0);
                clear_inputs();
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check_int($sformatf("%s_post_rst_busy_done k=%0d", tag, k), int'({busy, done}), 0);
                end
                return;
            end
            start          = (c == 0) || (c == extra_start);
            max_iterations = ITER_W'(cap);
            for (int i = 0; i < ROWS; i++)
                done_row[i] = (rgo >= 0 && row_dl[i] > 0 && c == rgo + row_dl[i]) ||
                              (noise && cgo >= 0 && c == cgo + 1);
            for (int i = 0; i < COLS; i++)
                done_col[i] = (cgo >= 0 && col_dl[i] > 0 && c == cgo + col_dl[i]) ||
                              (noise && rgo >= 0 && c == rgo + 1);
            syndrome_valid = (lsc >= 0 && c == lsc + 1 + s);
            // syndrome_zero idles high so an unqualified use would be caught
            syndrome_zero  = syndrome_valid ? (nsum == zero_it) : 1'b1;
        end
        clear_inputs();
        $display("decode %s: done at cycle %0d, rows=%0d iters=%0d conv=%0d tout=%0d",
                 tag, obs_done, obs_nrow, iters, conv, terr);
    endtask

    task automatic set_delays(input int rd, input int cd);
        foreach (row_dl[i]) row_dl[i] = rd;
        foreach (col_dl[i]) col_dl[i] = cd;
    endtask

    initial begin
        reset = 1'b1;
        max_iterations = '0;
        noise = 0;
        clear_inputs();
        repeat (2) @(negedge clk);
        check_int("reset_strobes", int'(obs_vec()), 0);
        check_int("reset_iters", int'(iters), 0);
        check_int("reset_flags", int'({conv, terr}), 0);
        reset = 1'b0;
        @(negedge clk);

        // cap 4, never converges, units answer 3 cycles after launch
        set_delays(3, 3); noise = 1;
        run_decode("cap4", 4, 0, 0, -1, -1);
        check_int("cap4_done_cycle", obs_done, 46);
        check_int("cap4_row_pulses", obs_nrow, 4);
        check_int("cap4_iters", int'(iters), 4);
        check_int("cap4_conv", int'(conv), 0);

        // zero syndrome on iteration 2 of 5, syndrome one cycle late
        set_delays(1, 1); noise = 0;
        run_decode("conv2", 5, 2, 1, -1, -1);
        check_int("conv2_done_cycle", obs_done, 18);
        check_int("conv2_row_pulses", obs_nrow, 2);
        check_int("conv2_iters", int'(iters), 2);
        check_int("conv2_conv", int'(conv), 1);

        // staggered row completions: bit0 @2, bit2 @5, bit1 @9
        set_delays(1, 1);
        row_dl[0] = 2; row_dl[1] = 9; row_dl[2] = 5;
        run_decode("stagger", 1, 0, 0, -1, -1);
        check_int("stagger_row_wb_cycle", obs_rowwb, 12);
        check_int("stagger_done_cycle", obs_done, 17);

        // column unit 5 never finishes
        set_delays(1, 1); col_dl[5] = 0; noise = 1;
        run_decode("hang", 3, 0, 0, -1, -1);
        check_int("hang_done_cycle", obs_done, 22);
        check_int("hang_tout", int'(terr), 1);
        check_int("hang_iters", int'(iters), 0);

        // cap 0 behaves as 1; start pulsed mid-decode must be ignored
        set_delays(1, 1); noise = 0;
        run_decode("cap0", 0, 0, 0, 4, -1);
        check_int("cap0_done_cycle", obs_done, 9);
        check_int("cap0_row_pulses", obs_nrow, 1);
        check_int("cap0_iters", int'(iters), 1);

        // reset during the second iteration's column wait
        set_delays(3, 3);
        run_decode("abort", 3, 0, 0, -1, 20);

        // scheduler must still decode normally after the abort
        set_delays(1, 1);
        run_decode("after_abort", 2, 0, 0, -1, -1);
        check_int("after_abort_iters", int'(iters), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
